// File: rtl/env_census_if.sv
// Environment census bus: sweep control, environment lookup port and census results.
// Clock and reset stay as plain ports on the census block.
interface env_census_if #(
    parameter int X_bits      = 8,
    parameter int Y_bits      = 7,
    parameter int SIGNAL_bits = 4
);
    logic                                start;
    logic                                hold;
    logic [X_bits-1:0]                   lookup_X;
    logic [Y_bits-1:0]                   lookup_Y;
    logic                                lookup_sugar;
    logic [SIGNAL_bits-1:0]              lookup_signal;
    logic                                busy;
    logic                                done;
    logic [X_bits+Y_bits-1:0]            sugar_count;
    logic [SIGNAL_bits+X_bits+Y_bits-1:0] signal_sum;
    logic [SIGNAL_bits-1:0]              signal_max;
    logic [X_bits-1:0]                   max_x;
    logic [Y_bits-1:0]                   max_y;

    modport master (
        output start, hold, lookup_sugar, lookup_signal,
        input  lookup_X, lookup_Y, busy, done,
        input  sugar_count, signal_sum, signal_max, max_x, max_y
    );

    modport slave (
        input  start, hold, lookup_sugar, lookup_signal,
        output lookup_X, lookup_Y, busy, done,
        output sugar_count, signal_sum, signal_max, max_x, max_y
    );
endinterface

// File: rtl/env_census.sv
// Environment census: raster-scans the grid through a one-cycle-latency lookup port and
// accumulates sugar count, signal sum and the strongest signal with its earliest cell.
module env_census #(
    parameter int X_bits      = 8,
    parameter int Y_bits      = 7,
    parameter int SIGNAL_bits = 4,
    parameter int GRID_W      = 160,
    parameter int GRID_H      = 120
) (
    input  logic         Clk,
    input  logic         Reset,
    env_census_if.slave  bus
);
    localparam int CNT_W = X_bits + Y_bits;
    localparam int SUM_W = SIGNAL_bits + X_bits + Y_bits;
    localparam logic [X_bits-1:0] X_LAST = X_bits'(GRID_W - 1);
    localparam logic [Y_bits-1:0] Y_LAST = Y_bits'(GRID_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_n_s;
    logic                   issue_s;
    logic                   clear_s;
    logic                   last_s;
    logic                   busy_n_s;
    logic                   done_n_s;

    logic [X_bits-1:0]      x_r;
    logic [Y_bits-1:0]      y_r;
    logic                   iss_valid_r;
    logic [X_bits-1:0]      iss_x_r;
    logic [Y_bits-1:0]      iss_y_r;
    logic                   busy_r;
    logic                   done_r;
    logic [CNT_W-1:0]       sugar_count_r;
    logic [SUM_W-1:0]       signal_sum_r;
    logic [SIGNAL_bits-1:0] signal_max_r;
    logic [X_bits-1:0]      max_x_r;
    logic [Y_bits-1:0]      max_y_r;

    assign last_s = (x_r == X_LAST) && (y_r == Y_LAST);

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state decode plus issue/clear strobes for the datapath
    always_comb begin
        state_n_s = state_r;
        issue_s   = 1'b0;
        clear_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_n_s = SCAN;
                    clear_s   = 1'b1;
                end else begin
                    state_n_s = IDLE;
                end
            end
            SCAN: begin
                if (!bus.hold) begin
                    issue_s = 1'b1;
                    if (last_s) begin
                        state_n_s = DRAIN;
                    end else begin
                        state_n_s = SCAN;
                    end
                end else begin
                    state_n_s = SCAN;
                end
            end
            DRAIN:   state_n_s = DONE;
            DONE:    state_n_s = IDLE;
            default: state_n_s = IDLE;
        endcase
        busy_n_s = (state_n_s == SCAN) || (state_n_s == DRAIN);
        done_n_s = (state_n_s == DONE);
    end

    // Status flags registered from the next state so they align with the state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_n_s;
            done_r <= done_n_s;
        end
    end

    // Lookup address walk and the issue pipeline stage that tags returning data
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_r         <= '0;
            y_r         <= '0;
            iss_valid_r <= 1'b0;
            iss_x_r     <= '0;
            iss_y_r     <= '0;
        end else begin
            iss_valid_r <= issue_s;
            if (issue_s) begin
                iss_x_r <= x_r;
                iss_y_r <= y_r;
            end else begin
                iss_x_r <= iss_x_r;
                iss_y_r <= iss_y_r;
            end
            // Parking the address at (0,0) after the final issue keeps DRAIN/DONE/IDLE at origin
            if (clear_s) begin
                x_r <= '0;
                y_r <= '0;
            end else if (issue_s) begin
                if (last_s) begin
                    x_r <= '0;
                    y_r <= '0;
                end else if (x_r == X_LAST) begin
                    x_r <= '0;
                    y_r <= y_r + Y_bits'(1);
                end else begin
                    x_r <= x_r + X_bits'(1);
                    y_r <= y_r;
                end
            end else begin
                x_r <= x_r;
                y_r <= y_r;
            end
        end
    end

    // Result accumulation from data returned one cycle after each issue
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sugar_count_r <= '0;
            signal_sum_r  <= '0;
            signal_max_r  <= '0;
            max_x_r       <= '0;
            max_y_r       <= '0;
        end else if (clear_s) begin
            sugar_count_r <= '0;
            signal_sum_r  <= '0;
            signal_max_r  <= '0;
            max_x_r       <= '0;
            max_y_r       <= '0;
        end else if (iss_valid_r) begin
            sugar_count_r <= sugar_count_r + CNT_W'(bus.lookup_sugar);
            signal_sum_r  <= signal_sum_r + SUM_W'(bus.lookup_signal);
            // Strict compare so ties keep the earliest raster cell
            if (bus.lookup_signal > signal_max_r) begin
                signal_max_r <= bus.lookup_signal;
                max_x_r      <= iss_x_r;
                max_y_r      <= iss_y_r;
            end else begin
                signal_max_r <= signal_max_r;
                max_x_r      <= max_x_r;
                max_y_r      <= max_y_r;
            end
        end else begin
            sugar_count_r <= sugar_count_r;
            signal_sum_r  <= signal_sum_r;
            signal_max_r  <= signal_max_r;
            max_x_r       <= max_x_r;
            max_y_r       <= max_y_r;
        end
    end

    assign bus.lookup_X    = x_r;
    assign bus.lookup_Y    = y_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.sugar_count = sugar_count_r;
    assign bus.signal_sum  = signal_sum_r;
    assign bus.signal_max  = signal_max_r;
    assign bus.max_x       = max_x_r;
    assign bus.max_y       = max_y_r;
endmodule

// File: tb/tb_env_census.sv
// Scoreboard bench for env_census on a 4x3 grid with a registered environment model
// that returns junk whenever the port is held by the writer.
module tb_env_census;
    localparam int XB = 8;
    localparam int YB = 7;
    localparam int SB = 4;
    localparam int GW = 4;
    localparam int GH = 3;
    localparam int NC = GW * GH;

    typedef struct {
        int sugar;
        int sum;
        int smax;
        int mx;
        int my;
        int edges;
    } exp_t;

    logic Clk;
    logic Reset;
    env_census_if #(.X_bits(XB), .Y_bits(YB), .SIGNAL_bits(SB)) bus ();

    env_census #(
        .X_bits(XB), .Y_bits(YB), .SIGNAL_bits(SB), .GRID_W(GW), .GRID_H(GH)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int        n_vec = 0;
    int        n_err = 0;
    int        done_cnt = 0;
    exp_t      sb_q[$];
    int        issue_q[$];
    logic      sugar_mem [NC];
    logic [3:0] sig_mem  [NC];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int env_idx(input logic [XB-1:0] x, input logic [YB-1:0] y);
        return int'(y) * GW + int'(x);
    endfunction

    // Environment lookup port: registered read, junk while the writer owns the port
    always @(posedge Clk) begin
        if (bus.hold) begin
            bus.lookup_sugar  <= 1'b1;
            bus.lookup_signal <= 4'hf;
        end else if (env_idx(bus.lookup_X, bus.lookup_Y) < NC) begin
            bus.lookup_sugar  <= sugar_mem[env_idx(bus.lookup_X, bus.lookup_Y)];
            bus.lookup_signal <= sig_mem[env_idx(bus.lookup_X, bus.lookup_Y)];
        end else begin
            bus.lookup_sugar  <= 1'b0;
            bus.lookup_signal <= 4'h0;
        end
    end

    // Records every address presented at an edge where the DUT may issue
    always @(posedge Clk) begin
        if (bus.busy === 1'b1 && bus.hold === 1'b0)
            issue_q.push_back(env_idx(bus.lookup_X, bus.lookup_Y));
        if (bus.done === 1'b1)
            done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int edges);
        exp_t e;
        e.sugar = 0; e.sum = 0; e.smax = 0; e.mx = 0; e.my = 0; e.edges = edges;
        for (int i = 0; i < NC; i++) begin
            if (sugar_mem[i]) e.sugar++;
            e.sum += int'(sig_mem[i]);
            if (int'(sig_mem[i]) > e.smax) begin
                e.smax = int'(sig_mem[i]);
                e.mx = i % GW;
                e.my = i / GW;
            end
        end
        return e;
    endfunction

    task automatic fill(input int kind);
        for (int i = 0; i < NC; i++) begin
            sugar_mem[i] = 1'b0;
            sig_mem[i]   = 4'h0;
            if (kind == 1) begin
                sugar_mem[i] = (i == 1) || (i == NC - 1);
                sig_mem[i]   = 4'((i % GW) + (i / GW));
            end else if (kind == 2) begin
                sig_mem[i] = (i == 2 || i == 5) ? 4'h7 : 4'h0;
            end
        end
    endtask

    task automatic run_sweep(input int hx0, input int hy0, input int hn0,
                             input int hx1, input int hy1, input int hn1,
                             input int s1, input int s2, input int rst_at,
                             input bit prestarted, input bit chain);
        int   cnt;
        int   hl;
        bit   u0;
        bit   u1;
        bit   got;
        int   d0;
        exp_t e;
        issue_q.delete();
        d0 = done_cnt;
        if (!prestarted) begin
            @(negedge Clk);
            bus.start = 1'b1;
        end
        @(posedge Clk);
        cnt = 0; hl = 0; u0 = 1'b0; u1 = 1'b0; got = 1'b0;
        while (cnt < 200) begin
            @(negedge Clk);
            if (cnt == 0) begin
                check_val("busy_after_start", bus.busy, 1);
                check_val("clear_on_start", bus.signal_sum, 0);
            end
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
            bus.start = (cnt + 1 == s1) || (cnt + 1 == s2);
            if (hl > 0) begin
                bus.hold = 1'b1;
                hl--;
            end else if (!u0 && hn0 > 0 && int'(bus.lookup_X) == hx0 && int'(bus.lookup_Y) == hy0) begin
                bus.hold = 1'b1; hl = hn0 - 1; u0 = 1'b1;
            end else if (!u1 && hn1 > 0 && int'(bus.lookup_X) == hx1 && int'(bus.lookup_Y) == hy1) begin
                bus.hold = 1'b1; hl = hn1 - 1; u1 = 1'b1;
            end else begin
                bus.hold = 1'b0;
            end
            @(posedge Clk);
            cnt++;
            if (cnt == rst_at) begin
                #1 Reset = 1'b1;
                #1;
                break;
            end
        end
        bus.hold = 1'b0;
        bus.start = 1'b0;
        if (rst_at > 0) begin
            check_val("rst_busy", bus.busy, 0);
            check_val("rst_done", bus.done, 0);
            check_val("rst_addr", {bus.lookup_X, bus.lookup_Y}, 0);
            check_val("rst_sugar", bus.sugar_count, 0);
            check_val("rst_sum", bus.signal_sum, 0);
            check_val("rst_max", {bus.signal_max, bus.max_x, bus.max_y}, 0);
            @(negedge Clk);
            Reset = 1'b0;
            repeat (20) @(negedge Clk);
            check_val("rst_no_done", done_cnt - d0, 0);
            check_val("rst_idle", bus.busy, 0);
            return;
        end
        check_val("done_seen", got, 1);
        if (!got) return;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check_val("done_edge", cnt, e.edges);
        check_val("done_busy_low", bus.busy, 0);
        check_val("sugar_count", bus.sugar_count, e.sugar);
        check_val("signal_sum", bus.signal_sum, e.sum);
        check_val("signal_max", bus.signal_max, e.smax);
        check_val("max_x", bus.max_x, e.mx);
        check_val("max_y", bus.max_y, e.my);
        check_val("done_addr", {bus.lookup_X, bus.lookup_Y}, 0);
        check_val("issue_count", issue_q.size() >= NC, 1);
        for (int i = 0; i < NC && i < issue_q.size(); i++)
            check_val("issue_order", issue_q[i], i);
        if (chain) bus.start = 1'b1;
        @(negedge Clk);
        check_val("done_one_cycle", bus.done, 0);
        check_val("single_done", done_cnt - d0, 1);
        if (chain) check_val("start_in_done_ignored", bus.busy, 0);
    endtask

    initial begin
        Reset = 1'b1;
        bus.start = 1'b0;
        bus.hold = 1'b0;
        fill(0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_val("reset_busy", bus.busy, 0);
        check_val("reset_done", bus.done, 0);
        check_val("reset_addr", {bus.lookup_X, bus.lookup_Y}, 0);
        check_val("reset_results", {bus.sugar_count, bus.signal_sum, bus.signal_max, bus.max_x, bus.max_y}, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // empty grid
        sb_q.push_back(model(GW * GH + 1));
        run_sweep(-1, -1, 0, -1, -1, 0, 0, 0, 0, 1'b0, 1'b0);

        // sugar at (1,0),(3,2), signal = x+y
        fill(1);
        sb_q.push_back(model(GW * GH + 1));
        run_sweep(-1, -1, 0, -1, -1, 0, 0, 0, 0, 1'b0, 1'b0);

        // same grid with writer stalls at (2,1) x3 and (0,2) x2
        sb_q.push_back(model(GW * GH + 1 + 5));
        run_sweep(2, 1, 3, 0, 2, 2, 0, 0, 0, 1'b0, 1'b0);

        // tie on signal 7 keeps earliest cell
        fill(2);
        sb_q.push_back(model(GW * GH + 1));
        run_sweep(-1, -1, 0, -1, -1, 0, 0, 0, 0, 1'b0, 1'b0);
        repeat (5) @(negedge Clk);
        check_val("stable_max", {bus.signal_max, bus.max_x, bus.max_y}, {4'd7, 8'd2, 7'd0});
        check_val("stable_sum", bus.signal_sum, 14);

        // reset mid-sweep, then a fresh full sweep
        fill(1);
        run_sweep(-1, -1, 0, -1, -1, 0, 0, 0, 6, 1'b0, 1'b0);
        sb_q.push_back(model(GW * GH + 1));
        run_sweep(-1, -1, 0, -1, -1, 0, 0, 0, 0, 1'b0, 1'b0);

        // start pulses inside the sweep are ignored; start held through DONE restarts from IDLE
        sb_q.push_back(model(GW * GH + 1));
        run_sweep(-1, -1, 0, -1, -1, 0, 4, 12, 0, 1'b0, 1'b1);
        sb_q.push_back(model(GW * GH + 1));
        run_sweep(-1, -1, 0, -1, -1, 0, 0, 0, 0, 1'b1, 1'b0);

        check_val("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/env_census.md
ENV_CENSUS -- requirements
Module: env_census

Interface
REQ-001 SHALL have parameter X_bits, default 8: width of grid X coordinate.
REQ-002 SHALL have parameter Y_bits, default 7: width of grid Y coordinate.
REQ-003 SHALL have parameter SIGNAL_bits, default 4: width of per-cell signal value.
REQ-004 SHALL have parameter GRID_W, default 160: cells per row; GRID_H, default 120: rows.
REQ-005 SHALL have port Clk  input  1: sole clock, all state rising-edge.
REQ-006 SHALL have port Reset  input  1: asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1: request one full census sweep.
REQ-008 SHALL have port hold  input  1: stall; environment port in use by writer.
REQ-009 SHALL have ports lookup_X  output  X_bits, lookup_Y  output  Y_bits: cell address to environment lookup port.
REQ-010 SHALL have ports lookup_sugar  input  1, lookup_signal  input  SIGNAL_bits: cell contents, valid one cycle after address.
REQ-011 SHALL have ports busy  output  1 (sweep in progress), done  output  1 (one-cycle completion pulse).
REQ-012 SHALL have ports sugar_count  output  X_bits+Y_bits: cells holding sugar; signal_sum  output  SIGNAL_bits+X_bits+Y_bits: sum of all signal values.
REQ-013 SHALL have ports signal_max  output  SIGNAL_bits, max_x  output  X_bits, max_y  output  Y_bits: strongest signal and its cell.

Function
REQ-014 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-015 IDLE: start=1 at an edge -> SCAN, clear all result registers, lookup address (0,0), busy=1.
REQ-016 SCAN, hold=0: address advances raster order, X first; X wraps GRID_W-1 -> 0 with Y+1.
REQ-017 SCAN, hold=1: address frozen, no new issue recorded; hold never drops or duplicates a cell.
REQ-018 Issue-valid register SHALL be set at each edge in SCAN with hold=0, capturing issued X,Y; accumulation occurs at the following edge from lookup_sugar/lookup_signal, regardless of hold at that edge.
REQ-019 Issue of cell (GRID_W-1, GRID_H-1) SHALL move SCAN -> DRAIN; DRAIN accumulates last cell, then -> DONE.
REQ-020 DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
REQ-021 With hold held low, done SHALL be high in the cycle following edge GRID_W*GRID_H+1, counting start-sampling edge as edge 0.
REQ-022 sugar_count increments by 1 per accumulated cell with lookup_sugar=1; signal_sum adds zero-extended lookup_signal; widths sized so no overflow at full grid.
REQ-023 signal_max/max_x/max_y update only on strictly greater signal; ties keep earliest raster cell; all-zero grid yields 0,(0,0).
REQ-024 start while busy SHALL be ignored; start in DONE cycle ignored; start held high restarts from IDLE next cycle.
REQ-025 Result outputs SHALL remain stable from DONE until next accepted start; intermediate values visible during SCAN are not guaranteed meaningful.
REQ-026 lookup_X/lookup_Y SHALL read (0,0) in IDLE and DONE.

Reset
REQ-027 Reset=1 SHALL immediately force IDLE, busy=0, done=0, all results 0, lookup address (0,0), issue-valid 0.
REQ-028 Reset mid-sweep SHALL abandon sweep; no done pulse; next start begins fresh from (0,0).

Verification (GRID_W=4, GRID_H=3, SIGNAL_bits=4)
REQ-029 Empty grid, start pulse, hold=0 -> done in cycle after edge 13; sugar_count=0, signal_sum=0, signal_max=0, max=(0,0).
REQ-030 Model with sugar at (1,0),(3,2), signal=X+Y per cell -> sugar_count=2, signal_sum=30, signal_max=5, max=(3,2).
REQ-031 Same model, hold=1 for 3 cycles at (2,1) and 2 cycles at (0,2) -> identical results, done delayed exactly 5 cycles, each address issued once.
REQ-032 Signal 7 at (2,0) and (1,1), else 0 -> signal_max=7, max=(2,0) (first in raster).
REQ-033 Reset asserted at edge 6 of sweep -> outputs 0 immediately, no done; new start -> correct full results.
REQ-034 start pulsed at edges 4 and 12 of sweep -> ignored, single done, results unchanged.
